// File: rtl/sky130_sram_pkg.sv
// Shared constants for the sky130 1rw1r SRAM behavioural model: the legal macro
// geometries, the byte width used by the write masks, and the port0 operation decode.
package sky130_sram_pkg;

    localparam int BYTE_W = 8;

    // sky130_sram_1kbyte_1rw1r_32x256_8
    localparam int CFG_32X256_DW = 32;
    localparam int CFG_32X256_AW = 8;
    localparam int CFG_32X256_NM = 4;

    // sky130_sram_1kbyte_1rw1r_8x1024_8
    localparam int CFG_8X1024_DW = 8;
    localparam int CFG_8X1024_AW = 10;
    localparam int CFG_8X1024_NM = 1;

    // sky130_sram_2kbyte_1rw1r_32x512_8
    localparam int CFG_32X512_DW = 32;
    localparam int CFG_32X512_AW = 9;
    localparam int CFG_32X512_NM = 4;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } port0_op_e;

    function automatic bit is_legal_cfg(input int dw, input int aw, input int nm);
        return (dw == CFG_32X256_DW && aw == CFG_32X256_AW && nm == CFG_32X256_NM) ||
               (dw == CFG_8X1024_DW && aw == CFG_8X1024_AW && nm == CFG_8X1024_NM) ||
               (dw == CFG_32X512_DW && aw == CFG_32X512_AW && nm == CFG_32X512_NM);
    endfunction

endpackage

// File: rtl/sky130_sram_in_reg.sv
// Stage-1 input register bank for one SRAM port. On reset the chip select
// returns to the deselected state so nothing stale reaches the array stage.
module sky130_sram_in_reg
    import sky130_sram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WMASKS = 4
) (
    input  logic                  clk0,
    input  logic                  rst_n,
    input  logic                  csb,
    input  logic                  web,
    input  logic [NUM_WMASKS-1:0] wmask,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  csb_reg,
    output logic                  web_reg,
    output logic [NUM_WMASKS-1:0] wmask_reg,
    output logic [ADDR_WIDTH-1:0] addr_reg,
    output logic [DATA_WIDTH-1:0] din_reg
);

    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            csb_reg   <= 1'b1;
            web_reg   <= 1'b0;
            wmask_reg <= '0;
            addr_reg  <= '0;
            din_reg   <= '0;
        end else begin
            csb_reg   <= csb;
            web_reg   <= web;
            wmask_reg <= wmask;
            addr_reg  <= addr;
            din_reg   <= din;
        end
    end

endmodule

// File: rtl/sky130_sram_1rw1r_model.sv
// Behavioural model of the sky130 OpenRAM 1rw1r macros: port0 read/write with
// byte masks, port1 read-only, registered inputs and registered read data.
module sky130_sram_1rw1r_model
    import sky130_sram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WMASKS = 4
) (
`ifdef USE_POWER_PINS
    inout  wire                   vccd1,
    inout  wire                   vssd1,
`endif
    input  logic                  clk0,
    input  logic                  rst_n,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (DATA_WIDTH != BYTE_W * NUM_WMASKS ||
        !is_legal_cfg(DATA_WIDTH, ADDR_WIDTH, NUM_WMASKS)) begin : g_bad_cfg
        $fatal(1, "sky130_sram_1rw1r_model: unsupported geometry DW=%0d AW=%0d NM=%0d",
               DATA_WIDTH, ADDR_WIDTH, NUM_WMASKS);
    end

    logic                  p0_csb_reg;
    logic                  p0_web_reg;
    logic [NUM_WMASKS-1:0] p0_wmask_reg;
    logic [ADDR_WIDTH-1:0] p0_addr_reg;
    logic [DATA_WIDTH-1:0] p0_din_reg;

    logic                  p1_csb_reg;
    logic                  p1_web_reg;
    logic [NUM_WMASKS-1:0] p1_wmask_reg;
    logic [ADDR_WIDTH-1:0] p1_addr_reg;
    logic [DATA_WIDTH-1:0] p1_din_reg;

    sky130_sram_in_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_WMASKS (NUM_WMASKS)
    ) u_in_reg0 (
        .clk0      (clk0),
        .rst_n     (rst_n),
        .csb       (csb0),
        .web       (web0),
        .wmask     (wmask0),
        .addr      (addr0),
        .din       (din0),
        .csb_reg   (p0_csb_reg),
        .web_reg   (p0_web_reg),
        .wmask_reg (p0_wmask_reg),
        .addr_reg  (p0_addr_reg),
        .din_reg   (p0_din_reg)
    );

    // Port1 is read-only: its write fields are tied off and fold away.
    sky130_sram_in_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_WMASKS (NUM_WMASKS)
    ) u_in_reg1 (
        .clk0      (clk0),
        .rst_n     (rst_n),
        .csb       (csb1),
        .web       (1'b1),
        .wmask     ('0),
        .addr      (addr1),
        .din       ('0),
        .csb_reg   (p1_csb_reg),
        .web_reg   (p1_web_reg),
        .wmask_reg (p1_wmask_reg),
        .addr_reg  (p1_addr_reg),
        .din_reg   (p1_din_reg)
    );

    logic unused_p1_write_fields;
    assign unused_p1_write_fields = ^{p1_web_reg, p1_wmask_reg, p1_din_reg};

    port0_op_e p0_op;

    always_comb begin
        p0_op = OP_IDLE;
        if (!p0_csb_reg) begin
            p0_op = p0_web_reg ? OP_READ : OP_WRITE;
        end
    end

    // A reset edge drops the write that was sampled on the previous edge.
    logic [NUM_WMASKS-1:0] byte_we;

    for (genvar gi = 0; gi < NUM_WMASKS; gi++) begin : g_byte_we
        assign byte_we[gi] = rst_n && (p0_op == OP_WRITE) && p0_wmask_reg[gi];
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk0) begin
        for (int k = 0; k < NUM_WMASKS; k++) begin
            if (byte_we[k]) begin
                mem[p0_addr_reg][k*BYTE_W +: BYTE_W] <= p0_din_reg[k*BYTE_W +: BYTE_W];
            end
        end
    end

    // Non-blocking reads see the pre-write word, so a same-edge port1 read
    // of a port0 write target returns the old data.
    logic [DATA_WIDTH-1:0] dout0_reg;
    logic [DATA_WIDTH-1:0] dout1_reg;

    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            dout0_reg <= '0;
            dout1_reg <= '0;
        end else begin
            if (p0_op == OP_READ) begin
                dout0_reg <= mem[p0_addr_reg];
            end
            if (!p1_csb_reg) begin
                dout1_reg <= mem[p1_addr_reg];
            end
        end
    end

    assign dout0 = dout0_reg;
    assign dout1 = dout1_reg;

endmodule

// File: tb/tb_sky130_sram_1rw1r_model.sv
// Scoreboard bench for the 1rw1r SRAM model across its three legal geometries:
// expected read data is queued when a read is issued and compared when dout updates.
module tb_sky130_sram_1rw1r_model;

    logic clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    logic rst_n;

    // 32x256
    logic        a_csb0, a_web0, a_csb1;
    logic [3:0]  a_wmask0;
    logic [7:0]  a_addr0, a_addr1;
    logic [31:0] a_din0, a_dout0, a_dout1;

    // 8x1024
    logic        b_csb0, b_web0, b_csb1;
    logic [0:0]  b_wmask0;
    logic [9:0]  b_addr0, b_addr1;
    logic [7:0]  b_din0, b_dout0, b_dout1;

    // 32x512
    logic        c_csb0, c_web0, c_csb1;
    logic [3:0]  c_wmask0;
    logic [8:0]  c_addr0, c_addr1;
    logic [31:0] c_din0, c_dout0, c_dout1;

    sky130_sram_1rw1r_model #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_WMASKS(4)) u_dut_a (
        .clk0(clk0), .rst_n(rst_n),
        .csb0(a_csb0), .web0(a_web0), .wmask0(a_wmask0), .addr0(a_addr0), .din0(a_din0),
        .dout0(a_dout0), .csb1(a_csb1), .addr1(a_addr1), .dout1(a_dout1)
    );

    sky130_sram_1rw1r_model #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .NUM_WMASKS(1)) u_dut_b (
        .clk0(clk0), .rst_n(rst_n),
        .csb0(b_csb0), .web0(b_web0), .wmask0(b_wmask0), .addr0(b_addr0), .din0(b_din0),
        .dout0(b_dout0), .csb1(b_csb1), .addr1(b_addr1), .dout1(b_dout1)
    );

    sky130_sram_1rw1r_model #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .NUM_WMASKS(4)) u_dut_c (
        .clk0(clk0), .rst_n(rst_n),
        .csb0(c_csb0), .web0(c_web0), .wmask0(c_wmask0), .addr0(c_addr0), .din0(c_din0),
        .dout0(c_dout0), .csb1(c_csb1), .addr1(c_addr1), .dout1(c_dout1)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        string       tag;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic a_idle();
        a_csb0 = 1'b1; a_web0 = 1'b1; a_wmask0 = 4'h0; a_din0 = 32'h0; a_csb1 = 1'b1;
    endtask

    task automatic a_wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] m);
        a_csb0 = 1'b0; a_web0 = 1'b0; a_addr0 = addr; a_din0 = data; a_wmask0 = m;
    endtask

    task automatic a_rd0(input logic [7:0] addr, input logic [31:0] exp, input string tag);
        a_csb0 = 1'b0; a_web0 = 1'b1; a_addr0 = addr; a_wmask0 = 4'h0;
        q0.push_back('{data: exp, tag: tag});
    endtask

    task automatic a_rd1(input logic [7:0] addr, input logic [31:0] exp, input string tag);
        a_csb1 = 1'b0; a_addr1 = addr;
        q1.push_back('{data: exp, tag: tag});
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_idle(); a_addr0 = 8'h0; a_addr1 = 8'h0;
        b_csb0 = 1'b1; b_web0 = 1'b1; b_wmask0 = 1'b0; b_din0 = 8'h0; b_csb1 = 1'b1;
        b_addr0 = 10'h0; b_addr1 = 10'h0;
        c_csb0 = 1'b1; c_web0 = 1'b1; c_wmask0 = 4'h0; c_din0 = 32'h0; c_csb1 = 1'b1;
        c_addr0 = 9'h0; c_addr1 = 9'h0;
        tick(); tick();
        rst_n = 1'b1;
        checks++;
        if (a_dout0 !== 32'h0) begin errors++; $display("FAIL reset_a_dout0: got %h want 00000000", a_dout0); end
        else $display("pass reset_a_dout0 %h", a_dout0);
        checks++;
        if (a_dout1 !== 32'h0) begin errors++; $display("FAIL reset_a_dout1: got %h want 00000000", a_dout1); end
        else $display("pass reset_a_dout1 %h", a_dout1);
        checks++;
        if (b_dout0 !== 8'h0 || b_dout1 !== 8'h0) begin
            errors++; $display("FAIL reset_b_dout: got %h/%h want 00/00", b_dout0, b_dout1);
        end else $display("pass reset_b_dout %h/%h", b_dout0, b_dout1);
        checks++;
        if (c_dout0 !== 32'h0 || c_dout1 !== 32'h0) begin
            errors++; $display("FAIL reset_c_dout: got %h/%h want 0/0", c_dout0, c_dout1);
        end else $display("pass reset_c_dout %h/%h", c_dout0, c_dout1);
    endtask

    task automatic test_write_read();
        exp_t e;
        a_wr(8'h05, 32'hDEADBEEF, 4'hF);
        tick();
        a_idle();
        a_rd0(8'h05, 32'hDEADBEEF, "wr_rd_p0");
        a_rd1(8'h05, 32'hDEADBEEF, "wr_rd_p1");
        tick();
        // Read sampled but not yet executed: dout0 must still hold its reset value.
        checks++;
        if (a_dout0 !== 32'h0) begin errors++; $display("FAIL latency_p0: got %h want 00000000", a_dout0); end
        else $display("pass latency_p0 %h", a_dout0);
        a_idle();
        tick();
        e = q0.pop_front(); checks++;
        if (a_dout0 !== e.data) begin errors++; $display("FAIL %s: got %h want %h", e.tag, a_dout0, e.data); end
        else $display("pass %s %h", e.tag, a_dout0);
        e = q1.pop_front(); checks++;
        if (a_dout1 !== e.data) begin errors++; $display("FAIL %s: got %h want %h", e.tag, a_dout1, e.data); end
        else $display("pass %s %h", e.tag, a_dout1);
    endtask

    task automatic test_byte_mask();
        exp_t e;
        a_wr(8'h20, 32'hAABBCCDD, 4'hF); tick();
        a_wr(8'h20, 32'h11223344, 4'h5); tick();
        a_wr(8'h20, 32'hFFFFFFFF, 4'h0); tick();
        a_wr(8'h22, 32'h00000000, 4'hF); tick();
        a_wr(8'h22, 32'hFFFFFFAA, 4'h1); tick();
        a_wr(8'h22, 32'hFFFFBBFF, 4'h2); tick();
        a_wr(8'h22, 32'hFFCCFFFF, 4'h4); tick();
        a_wr(8'h22, 32'hDDFFFFFF, 4'h8); tick();
        a_idle();
        a_rd0(8'h20, 32'hAA22CC44, "byte_mask_5");
        a_rd1(8'h22, 32'hDDCCBBAA, "byte_mask_each");
        tick();
        a_idle();
        tick();
        e = q0.pop_front(); checks++;
        if (a_dout0 !== e.data) begin errors++; $display("FAIL %s: got %h want %h", e.tag, a_dout0, e.data); end
        else $display("pass %s %h", e.tag, a_dout0);
        e = q1.pop_front(); checks++;
        if (a_dout1 !== e.data) begin errors++; $display("FAIL %s: got %h want %h", e.tag, a_dout1, e.data); end
        else $display("pass %s %h", e.tag, a_dout1);
        a_wr(8'h21, 32'h00000001, 4'hF); tick();
        a_idle(); tick();
        checks++;
        if (a_dout0 !== 32'hAA22CC44) begin errors++; $display("FAIL write_holds_dout0: got %h want aa22cc44", a_dout0); end
        else $display("pass write_holds_dout0 %h", a_dout0);
    endtask

    task automatic test_collision();
        exp_t e;
        a_wr(8'h10, 32'h0BADC0DE, 4'hF); tick();
        a_wr(8'h10, 32'h12345678, 4'hF);
        a_rd1(8'h10, 32'h0BADC0DE, "collide_old");
        tick();
        a_idle();
        a_rd1(8'h10, 32'h12345678, "collide_new");
        tick();
        e = q1.pop_front(); checks++;
        if (a_dout1 !== e.data) begin errors++; $display("FAIL %s: got %h want %h", e.tag, a_dout1, e.data); end
        else $display("pass %s %h", e.tag, a_dout1);
        a_idle();
        tick();
        e = q1.pop_front(); checks++;
        if (a_dout1 !== e.data) begin errors++; $display("FAIL %s: got %h want %h", e.tag, a_dout1, e.data); end
        else $display("pass %s %h", e.tag, a_dout1);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] wd [8];
        for (int i = 0; i < 8; i++) begin
            wd[i] = $urandom;
            a_wr(8'(8'h40 + i), wd[i], 4'hF);
            tick();
        end
        for (int i = 0; i <= 8; i++) begin
            a_idle();
            if (i < 8) begin
                a_rd0(8'(8'h40 + i), wd[i], $sformatf("b2b_p0_%0d", i));
                a_rd1(8'(8'h47 - i), wd[7-i], $sformatf("b2b_p1_%0d", 7 - i));
            end
            tick();
            if (i > 0) begin
                e = q0.pop_front(); checks++;
                if (a_dout0 !== e.data) begin errors++; $display("FAIL %s: got %h want %h", e.tag, a_dout0, e.data); end
                else $display("pass %s %h", e.tag, a_dout0);
                e = q1.pop_front(); checks++;
                if (a_dout1 !== e.data) begin errors++; $display("FAIL %s: got %h want %h", e.tag, a_dout1, e.data); end
                else $display("pass %s %h", e.tag, a_dout1);
            end
        end
    endtask

    task automatic test_deselect_hold();
        exp_t e;
        a_wr(8'h30, 32'hCAFEF00D, 4'hF); tick();
        a_idle();
        a_rd0(8'h30, 32'hCAFEF00D, "hold_load_p0");
        a_rd1(8'h30, 32'hCAFEF00D, "hold_load_p1");
        tick();
        a_idle();
        tick();
        e = q0.pop_front(); checks++;
        if (a_dout0 !== e.data) begin errors++; $display("FAIL %s: got %h want %h", e.tag, a_dout0, e.data); end
        else $display("pass %s %h", e.tag, a_dout0);
        e = q1.pop_front(); checks++;
        if (a_dout1 !== e.data) begin errors++; $display("FAIL %s: got %h want %h", e.tag, a_dout1, e.data); end
        else $display("pass %s %h", e.tag, a_dout1);
        // Deselected with a write pattern on the pins: nothing may reach the array.
        for (int i = 0; i < 3; i++) begin
            a_csb0 = 1'b1; a_web0 = 1'b0; a_wmask0 = 4'hF; a_din0 = 32'h0000BAD0 + i;
            a_addr0 = 8'h05; a_csb1 = 1'b1; a_addr1 = 8'h05;
            tick();
            checks++;
            if (a_dout0 !== 32'hCAFEF00D) begin errors++; $display("FAIL hold_p0_%0d: got %h want cafef00d", i, a_dout0); end
            else $display("pass hold_p0_%0d %h", i, a_dout0);
            checks++;
            if (a_dout1 !== 32'hCAFEF00D) begin errors++; $display("FAIL hold_p1_%0d: got %h want cafef00d", i, a_dout1); end
            else $display("pass hold_p1_%0d %h", i, a_dout1);
        end
        a_idle();
    endtask

    task automatic test_reset_mid_write();
        exp_t e;
        a_wr(8'h05, 32'h99999999, 4'hF);
        tick();
        rst_n = 1'b0;
        a_idle();
        tick();
        rst_n = 1'b1;
        checks++;
        if (a_dout0 !== 32'h0) begin errors++; $display("FAIL rst_mid_dout0: got %h want 00000000", a_dout0); end
        else $display("pass rst_mid_dout0 %h", a_dout0);
        checks++;
        if (a_dout1 !== 32'h0) begin errors++; $display("FAIL rst_mid_dout1: got %h want 00000000", a_dout1); end
        else $display("pass rst_mid_dout1 %h", a_dout1);
        a_rd0(8'h05, 32'hDEADBEEF, "rst_dropped_write");
        a_rd1(8'h20, 32'hAA22CC44, "rst_keeps_array");
        tick();
        a_idle();
        tick();
        e = q0.pop_front(); checks++;
        if (a_dout0 !== e.data) begin errors++; $display("FAIL %s: got %h want %h", e.tag, a_dout0, e.data); end
        else $display("pass %s %h", e.tag, a_dout0);
        e = q1.pop_front(); checks++;
        if (a_dout1 !== e.data) begin errors++; $display("FAIL %s: got %h want %h", e.tag, a_dout1, e.data); end
        else $display("pass %s %h", e.tag, a_dout1);
    endtask

    task automatic test_boundary_8x1024();
        exp_t e;
        b_csb0 = 1'b0; b_web0 = 1'b0; b_wmask0 = 1'b1;
        b_addr0 = 10'd1023; b_din0 = 8'hA5; tick();
        b_addr0 = 10'd0;    b_din0 = 8'h5A; tick();
        b_addr0 = 10'd511;  b_din0 = 8'h3C; tick();
        b_addr0 = 10'd1023; b_din0 = 8'hFF; b_wmask0 = 1'b0; tick();
        b_web0 = 1'b1; b_wmask0 = 1'b0; b_csb1 = 1'b0;
        b_addr0 = 10'd1023; q0.push_back('{data: 32'h000000A5, tag: "b_top_p0"});
        b_addr1 = 10'd0;    q1.push_back('{data: 32'h0000005A, tag: "b_zero_p1"});
        tick();
        b_addr0 = 10'd0;    q0.push_back('{data: 32'h0000005A, tag: "b_zero_p0"});
        b_addr1 = 10'd1023; q1.push_back('{data: 32'h000000A5, tag: "b_top_p1"});
        tick();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                b_csb0 = 1'b1;
                b_addr1 = 10'd511; q1.push_back('{data: 32'h0000003C, tag: "b_mid_p1"});
            end else begin
                b_csb1 = 1'b1;
            end
            e = q0.pop_front(); checks++;
            if ({24'h0, b_dout0} !== e.data) begin errors++; $display("FAIL %s: got %h want %h", e.tag, b_dout0, e.data); end
            else $display("pass %s %h", e.tag, b_dout0);
            e = q1.pop_front(); checks++;
            if ({24'h0, b_dout1} !== e.data) begin errors++; $display("FAIL %s: got %h want %h", e.tag, b_dout1, e.data); end
            else $display("pass %s %h", e.tag, b_dout1);
            tick();
        end
        e = q1.pop_front(); checks++;
        if ({24'h0, b_dout1} !== e.data) begin errors++; $display("FAIL %s: got %h want %h", e.tag, b_dout1, e.data); end
        else $display("pass %s %h", e.tag, b_dout1);
    endtask

    task automatic test_boundary_32x512();
        exp_t e;
        c_csb0 = 1'b0; c_web0 = 1'b0; c_wmask0 = 4'hF;
        c_addr0 = 9'd511; c_din0 = 32'h600DF00D; tick();
        c_addr0 = 9'd255; c_din0 = 32'h11111111; tick();
        c_addr0 = 9'd0;   c_din0 = 32'h22222222; tick();
        c_web0 = 1'b1; c_wmask0 = 4'h0; c_csb1 = 1'b0;
        c_addr1 = 9'd511; q1.push_back('{data: 32'h600DF00D, tag: "c_top_p1"});
        c_addr0 = 9'd255; q0.push_back('{data: 32'h11111111, tag: "c_255_p0"});
        tick();
        c_csb0 = 1'b1;
        c_addr1 = 9'd0;   q1.push_back('{data: 32'h22222222, tag: "c_zero_p1"});
        tick();
        c_csb1 = 1'b1;
        e = q1.pop_front(); checks++;
        if (c_dout1 !== e.data) begin errors++; $display("FAIL %s: got %h want %h", e.tag, c_dout1, e.data); end
        else $display("pass %s %h", e.tag, c_dout1);
        e = q0.pop_front(); checks++;
        if (c_dout0 !== e.data) begin errors++; $display("FAIL %s: got %h want %h", e.tag, c_dout0, e.data); end
        else $display("pass %s %h", e.tag, c_dout0);
        tick();
        e = q1.pop_front(); checks++;
        if (c_dout1 !== e.data) begin errors++; $display("FAIL %s: got %h want %h", e.tag, c_dout1, e.data); end
        else $display("pass %s %h", e.tag, c_dout1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_byte_mask();
        test_collision();
        test_back_to_back();
        test_deselect_hold();
        test_reset_mid_write();
        test_boundary_8x1024();
        test_boundary_32x512();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: q0=%0d q1=%0d left, want 0/0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
